// File: rtl/equalizer.sv
// Audio equalizer: I2S codec master with per-frame gain and level meter, volume read
// from channel 0 of a SPI ADC.
module equalizer (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] LED,
  output logic       A2D_SS_n,
  output logic       A2D_SCLK,
  output logic       A2D_MOSI,
  input  logic       A2D_MISO,
  output logic       MCLK,
  output logic       SCLK,
  output logic       LRCLK,
  input  logic       SDout,
  output logic       SDin,
  output logic       RSTn,
  output logic       AMP_ON
);

  localparam logic [9:0]         SPI_GAP  = 10'd32;
  localparam logic [9:0]         SPI_LAST = 10'd543;
  localparam logic [2:0]         ADC_CH   = 3'd0;
  localparam logic [15:0]        ADC_CMD  = {2'b00, ADC_CH, 11'd0};
  localparam logic signed [28:0] SAT_MAX  = 29'sd32767;
  localparam logic signed [28:0] SAT_MIN  = -29'sd32768;

  logic [9:0]         cnt_q, cnt_d;
  logic               rstn_q, rstn_d, amp_q, amp_d;
  logic [14:0]        rx_sr_q, rx_sr_d;
  logic signed [15:0] left_rx_q, left_rx_d;
  logic signed [15:0] tx_l_q, tx_l_d, tx_r_q, tx_r_d;
  logic [7:0]         led_q, led_d;
  logic               sdin_q, sdin_d;
  logic [9:0]         spi_q, spi_d;
  logic               ss_n_q, ss_n_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic [11:0]        miso_sr_q, miso_sr_d;
  logic [11:0]        vol_q, vol_d;
  logic [4:0]         slot_rx, slot_tx;
  logic signed [15:0] rx_word, tx_word;

  function automatic logic signed [15:0] sat16(input logic signed [28:0] v);
    if (v > SAT_MAX)      return 16'sh7fff;
    else if (v < SAT_MIN) return 16'sh8000;
    else                  return v[15:0];
  endfunction

  function automatic logic signed [15:0] apply_gain(input logic signed [15:0] s,
                                                    input logic [11:0] g);
    logic signed [28:0] a, b, prod;
    a    = {{13{s[15]}}, s};
    b    = $signed({17'd0, g});
    prod = a * b;
    return sat16(prod >>> 11);
  endfunction

  function automatic logic [7:0] level(input logic signed [15:0] s);
    logic [14:0] mag;
    if (s == 16'sh8000) mag = 15'h7fff;
    else if (s[15])     mag = 15'(-s);
    else                mag = s[14:0];
    return 8'(mag >> 7);
  endfunction

  // SPI cycle: 32 clk with SS_n high, then 16 bits of 32 clk (SCLK low half first).
  function automatic logic [2:0] spi_pins(input logic [9:0] sp);
    logic [8:0] off;
    if (sp < SPI_GAP) return 3'b100;
    off = 9'(sp - SPI_GAP);
    return {1'b0, |(off & 9'h010), ADC_CMD[4'd15 - 4'(off >> 5)]};
  endfunction

  always_comb begin
    cnt_d     = cnt_q + 10'd1;
    rstn_d    = rstn_q | (cnt_q == 10'd1023);
    amp_d     = amp_q | rstn_q;
    rx_sr_d   = rx_sr_q;
    left_rx_d = left_rx_q;
    tx_l_d    = tx_l_q;
    tx_r_d    = tx_r_q;
    led_d     = led_q;
    sdin_d    = sdin_q;
    slot_rx   = cnt_q[8:4];
    slot_tx   = cnt_d[8:4];
    rx_word   = $signed({rx_sr_q, SDout});
    tx_word   = cnt_d[9] ? tx_r_q : tx_l_q;

    // Codec receive on SCLK rising; right word completes the pair.
    if (cnt_q[3:0] == 4'd7 && slot_rx >= 5'd1 && slot_rx <= 5'd16) begin
      rx_sr_d = rx_word[14:0];
      if (slot_rx == 5'd16) begin
        if (!cnt_q[9]) begin
          left_rx_d = rx_word;
        end else begin
          tx_l_d = apply_gain(left_rx_q, vol_q);
          tx_r_d = apply_gain(rx_word, vol_q);
          led_d  = level(tx_l_d);
        end
      end
    end

    // Codec transmit on SCLK falling, one-period I2S delay after LRCLK edge.
    if (cnt_q[3:0] == 4'd15) begin
      if (slot_tx >= 5'd1 && slot_tx <= 5'd16) sdin_d = tx_word[4'(5'd16 - slot_tx)];
      else                                     sdin_d = 1'b0;
    end

    spi_d                    = (spi_q == SPI_LAST) ? 10'd0 : spi_q + 10'd1;
    {ss_n_d, sclk_d, mosi_d} = spi_pins(spi_d);
    miso_sr_d                = miso_sr_q;
    vol_d                    = vol_q;
    if (!ss_n_d && !sclk_q && sclk_d) miso_sr_d = {miso_sr_q[10:0], A2D_MISO};
    if (spi_q == SPI_LAST)            vol_d     = miso_sr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      rstn_q    <= 1'b0;
      amp_q     <= 1'b0;
      rx_sr_q   <= '0;
      left_rx_q <= '0;
      tx_l_q    <= '0;
      tx_r_q    <= '0;
      led_q     <= '0;
      sdin_q    <= 1'b0;
      spi_q     <= '0;
      ss_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      miso_sr_q <= '0;
      vol_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      rstn_q    <= rstn_d;
      amp_q     <= amp_d;
      rx_sr_q   <= rx_sr_d;
      left_rx_q <= left_rx_d;
      tx_l_q    <= tx_l_d;
      tx_r_q    <= tx_r_d;
      led_q     <= led_d;
      sdin_q    <= sdin_d;
      spi_q     <= spi_d;
      ss_n_q    <= ss_n_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      miso_sr_q <= miso_sr_d;
      vol_q     <= vol_d;
    end
  end

  assign MCLK     = cnt_q[1];
  assign SCLK     = cnt_q[3];
  assign LRCLK    = cnt_q[9];
  assign RSTn     = rstn_q;
  assign AMP_ON   = amp_q;
  assign SDin     = sdin_q;
  assign LED      = led_q;
  assign A2D_SS_n = ss_n_q;
  assign A2D_SCLK = sclk_q;
  assign A2D_MOSI = mosi_q;

endmodule

// File: tb/tb_equalizer.sv
// Randomized bench for equalizer: models the codec and SPI ADC, predicts each frame's
// output words and LED from the gain/saturation rules.
module tb_equalizer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] LED;
  logic       A2D_SS_n, A2D_SCLK, A2D_MOSI, A2D_MISO;
  logic       MCLK, SCLK, LRCLK, SDout, SDin, RSTn, AMP_ON;

  equalizer dut (
    .clk(clk), .rst(rst), .LED(LED),
    .A2D_SS_n(A2D_SS_n), .A2D_SCLK(A2D_SCLK), .A2D_MOSI(A2D_MOSI), .A2D_MISO(A2D_MISO),
    .MCLK(MCLK), .SCLK(SCLK), .LRCLK(LRCLK), .SDout(SDout), .SDin(SDin),
    .RSTn(RSTn), .AMP_ON(AMP_ON)
  );

  always #10 clk = ~clk;

  localparam int RND = 100000;

  int checks = 0;
  int errors = 0;

  // ADC slave: presents {4'b0, adc_val} MSB first, shifting on SCLK falling.
  logic [11:0] adc_val = 12'd0;
  logic [15:0] adc_sr  = 16'd0;
  assign A2D_MISO = adc_sr[15];
  always @(negedge A2D_SS_n) adc_sr = {4'b0000, adc_val};
  always @(negedge A2D_SCLK) if (!A2D_SS_n) adc_sr = {adc_sr[14:0], 1'b0};

  int adc_tbl[7];
  int dir_l[7];
  int dir_r[7];
  int in_l[32];
  int in_r[32];
  int vol_f[32];
  bit vol_known[32];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int gain_ref(input int s, input int v);
    longint p;
    longint q;
    p = longint'(s) * longint'(v);
    if (p >= 0) q = p / 2048;
    else        q = -((-p + 2047) / 2048);
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  function automatic int led_ref(input int o);
    int m;
    m = (o < 0) ? -o : o;
    if (m > 32767) m = 32767;
    return (m / 128) % 256;
  endfunction

  function automatic int pick();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 32767;
    if (r == 1) return -32768;
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_led"},    int'(LED), 0);
    chk({tag, "_ss_n"},   int'(A2D_SS_n), 1);
    chk({tag, "_a2dclk"}, int'(A2D_SCLK), 0);
    chk({tag, "_mosi"},   int'(A2D_MOSI), 0);
    chk({tag, "_mclk"},   int'(MCLK), 0);
    chk({tag, "_sclk"},   int'(SCLK), 0);
    chk({tag, "_lrclk"},  int'(LRCLK), 0);
    chk({tag, "_rstn"},   int'(RSTn), 0);
    chk({tag, "_amp"},    int'(AMP_ON), 0);
    chk({tag, "_sdin"},   int'(SDin), 0);
  endtask

  // Releases reset and runs nframes frames; each group of 4 frames uses one table row.
  task automatic run_session(input int nframes, input int phase0);
    int c, f, slot, half, rises, high_len, p, el, er;
    logic ss_prev, sclk_prev, dc_bad;
    logic [15:0] cap_l, cap_r, wv;
    for (int i = 0; i < nframes; i++) begin
      p            = phase0 + i / 4;
      vol_f[i]     = adc_tbl[p];
      vol_known[i] = (i % 4 != 0) || (i == 0);
      in_l[i]      = pick();
      in_r[i]      = pick();
      if (i % 4 == 1) begin
        if (dir_l[p] != RND) in_l[i] = dir_l[p];
        if (dir_r[p] != RND) in_r[i] = dir_r[p];
      end
    end
    adc_val = 12'(adc_tbl[phase0]);
    SDout   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset("release");
    ss_prev = 1'b1; sclk_prev = 1'b0; rises = 0; high_len = 1;
    dc_bad = 1'b0; cap_l = '0; cap_r = '0;
    for (int k = 1; k < nframes * 1024; k++) begin
      @(posedge clk);
      #1;
      c    = k % 1024;
      f    = k / 1024;
      slot = (c >> 4) & 31;
      half = (c >> 9) & 1;
      if (c == 0 && f % 4 == 0) adc_val = 12'(adc_tbl[phase0 + f / 4]);

      chk("mclk",   int'(MCLK),   (c >> 1) & 1);
      chk("sclk",   int'(SCLK),   (c >> 3) & 1);
      chk("lrclk",  int'(LRCLK),  half);
      chk("rstn",   int'(RSTn),   (k >= 1024) ? 1 : 0);
      chk("amp_on", int'(AMP_ON), (k >= 1025) ? 1 : 0);

      if (A2D_SS_n && !ss_prev) begin
        chk("spi_sclks", rises, 16);
        rises    = 0;
        high_len = 1;
      end else if (A2D_SS_n) begin
        high_len++;
      end else if (ss_prev) begin
        chk("spi_gap_ge32", int'(high_len >= 32), 1);
      end
      if (!A2D_SS_n && A2D_SCLK && !sclk_prev) rises++;
      chk("spi_idle_low", int'(A2D_SS_n && A2D_SCLK), 0);
      chk("mosi_ch0", int'(A2D_MOSI), 0);
      ss_prev   = A2D_SS_n;
      sclk_prev = A2D_SCLK;

      wv    = half ? 16'(in_r[f]) : 16'(in_l[f]);
      SDout = (slot >= 1 && slot <= 16) ? wv[16 - slot] : 1'b0;

      if ((c & 15) == 8) begin
        if (slot >= 1 && slot <= 16) begin
          if (half == 1) cap_r[16 - slot] = SDin;
          else           cap_l[16 - slot] = SDin;
        end else if (SDin) begin
          dc_bad = 1'b1;
        end
      end

      if (c == 1023) begin
        if (f == 0 || vol_known[f - 1]) begin
          el = (f == 0) ? 0 : gain_ref(in_l[f - 1], vol_f[f - 1]);
          er = (f == 0) ? 0 : gain_ref(in_r[f - 1], vol_f[f - 1]);
          chk("sdin_left",  int'($signed(cap_l)), el);
          chk("sdin_right", int'($signed(cap_r)), er);
        end
        if (vol_known[f]) chk("led", int'(LED), led_ref(gain_ref(in_l[f], vol_f[f])));
        chk("sdin_pad_zero", int'(dc_bad), 0);
        dc_bad = 1'b0; cap_l = '0; cap_r = '0;
      end
    end
  endtask

  initial begin
    adc_tbl = '{12'h800, 12'hFFF, 12'h400, 12'h000, 0, 12'h800, 0};
    dir_l   = '{1000,  20000, RND,    RND, RND, RND, RND};
    dir_r   = '{-1000, RND,   -32768, RND, RND, RND, RND};
    adc_tbl[4] = int'($urandom_range(0, 4095));
    adc_tbl[6] = int'($urandom_range(0, 4095));

    rst   = 1'b1;
    SDout = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst_hold");

    run_session(20, 0);

    for (int i = 0; i < 2000 && A2D_SS_n; i++) @(posedge clk);
    #1;
    chk("spi_active_found", int'(A2D_SS_n), 0);
    repeat (40) @(posedge clk);
    #5;
    rst = 1'b1;
    #1;
    check_reset("rst_async");
    repeat (4) @(posedge clk);
    #1;
    check_reset("rst_async_hold");

    run_session(8, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
